// File: rtl/exibidor_sequencia_pkg.sv
// Shared definitions for the sequence player: state codes and nibble select helper.
package exibidor_sequencia_pkg;

  localparam int NIB_W = 4;

  // Codes are also decoded by the 7-segment debug display, keep them stable.
  typedef enum logic [3:0] {
    OCIOSO   = 4'd0,
    ENDERECA = 4'd1,
    LE       = 4'd2,
    ACENDE   = 4'd3,
    APAGA    = 4'd4,
    FIM      = 4'd5
  } estado_t;

  function automatic logic [NIB_W-1:0] nibble(input logic [4*NIB_W-1:0] w,
                                              input logic [1:0]         k);
    return w[k*NIB_W +: NIB_W];
  endfunction

endpackage

// File: rtl/exibidor_sequencia_if.sv
// Control-unit / ROM side signals of the sequence player, grouped as one bus.
interface exibidor_sequencia_if;
  import exibidor_sequencia_pkg::*;

  logic             iniciar;
  logic             abortar;
  logic [15:0]      indices;
  logic [NIB_W-1:0] rom_data;
  logic [NIB_W-1:0] rom_addr;
  logic [3:0]       leds;
  logic             exibindo;
  logic             pronto;
  logic [3:0]       db_estado;

  modport master (
    output iniciar, abortar, indices, rom_data,
    input  rom_addr, leds, exibindo, pronto, db_estado
  );

  modport slave (
    input  iniciar, abortar, indices, rom_data,
    output rom_addr, leds, exibindo, pronto, db_estado
  );

endinterface

// File: rtl/exibidor_sequencia_temporizador_carga.sv
// Loadable down-counter that stops at zero; load has priority over counting.
module temporizador_carga #(
  parameter int CNT_W = 25
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             carrega,
  input  logic [CNT_W-1:0] valor,
  input  logic             conta,
  output logic             zero
);

  localparam logic [CNT_W-1:0] UM = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (carrega) begin
      r_cnt <= valor;
    end else if (conta && (r_cnt != '0)) begin
      r_cnt <= r_cnt - UM;
    end
  end

  assign zero = (r_cnt == '0);

endmodule

// File: rtl/exibidor_sequencia.sv
// Plays the latched four-step ROM pattern sequence on the LEDs, then pulses pronto.
module exibidor_sequencia
  import exibidor_sequencia_pkg::*;
#(
  parameter int T_ON     = 25000000,
  parameter int T_OFF    = 12500000,
  parameter int N_PASSOS = 4,
  parameter int CNT_W    = 25
) (
  input  logic                 clock,
  input  logic                 reset_n,
  exibidor_sequencia_if.slave  bus
);

  localparam logic [CNT_W-1:0] CARGA_ON  = CNT_W'(T_ON - 1);
  localparam logic [CNT_W-1:0] CARGA_OFF = CNT_W'(T_OFF - 1);
  localparam logic [1:0]       ULTIMO    = 2'(N_PASSOS - 1);

  estado_t          r_estado;
  logic [15:0]      r_indices;
  logic [1:0]       r_passo;
  logic [3:0]       r_leds;
  logic             r_pronto;

  logic             w_carrega;
  logic             w_conta;
  logic [CNT_W-1:0] w_valor;
  logic             w_zero;

  temporizador_carga #(.CNT_W(CNT_W)) u_temporizador (
    .clock   (clock),
    .reset_n (reset_n),
    .carrega (w_carrega),
    .valor   (w_valor),
    .conta   (w_conta),
    .zero    (w_zero)
  );

  // One timer serves both the lit and the dark phase; ACENDE reloads it on expiry.
  always_comb begin
    w_carrega = 1'b0;
    w_conta   = 1'b0;
    w_valor   = CARGA_ON;
    case (r_estado)
      LE: begin
        w_carrega = 1'b1;
      end
      ACENDE: begin
        if (w_zero) begin
          w_carrega = 1'b1;
          w_valor   = CARGA_OFF;
        end else begin
          w_conta = 1'b1;
        end
      end
      APAGA: begin
        w_conta = 1'b1;
      end
      default: begin
        w_carrega = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado  <= OCIOSO;
      r_indices <= '0;
      r_passo   <= '0;
      r_leds    <= '0;
      r_pronto  <= 1'b0;
    end else begin
      r_pronto <= 1'b0;
      if (bus.abortar) begin
        r_estado <= OCIOSO;
        r_leds   <= '0;
        r_passo  <= '0;
      end else begin
        case (r_estado)
          OCIOSO: begin
            r_leds <= '0;
            if (bus.iniciar) begin
              r_indices <= bus.indices;
              r_passo   <= '0;
              r_estado  <= ENDERECA;
            end
          end
          // Address is already on rom_addr; this state only waits out the ROM latency.
          ENDERECA: r_estado <= LE;
          LE: begin
            r_leds   <= bus.rom_data;
            r_estado <= ACENDE;
          end
          ACENDE: begin
            if (w_zero) begin
              r_leds   <= '0;
              r_estado <= APAGA;
            end
          end
          APAGA: begin
            if (w_zero) begin
              if (r_passo == ULTIMO) begin
                r_estado <= FIM;
                r_pronto <= 1'b1;
              end else begin
                r_passo  <= r_passo + 2'd1;
                r_estado <= ENDERECA;
              end
            end
          end
          FIM:     r_estado <= OCIOSO;
          default: begin
            r_estado <= OCIOSO;
            r_leds   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.rom_addr  = nibble(r_indices, r_passo);
  assign bus.leds      = r_leds;
  assign bus.pronto    = r_pronto;
  assign bus.exibindo  = (r_estado != OCIOSO);
  assign bus.db_estado = r_estado;

endmodule
